actor_token_arbiter: RTL and testbench
======================================

// Module: actor_token_arbiter
// PURPOSE
//  Merges the output token ports of NUM_SRC dataflow actors onto one consumer
//  port. Uses the SEND/RDY/ACK/COUNT/DATA port protocol of the generated actors.
//  Each source has a one-token holding register. A round-robin grant moves
//  tokens into a registered output stage. Sits between actor source ports
//  (e.g. source2_*) and the shared downstream consumer.
// PARAMETERS
//  NUM_SRC  2   number of producer ports (2..8)
//  DATA_W   8   token data width
//  CNT_W    16  COUNT field width
//  SRC_W    1   source-id width, = max(1,$clog2(NUM_SRC))
// PORTS
//  CLK        in   1               clock, rising edge
//  RESET      in   1               asynchronous, active-high reset
//  src_SEND   in   NUM_SRC         producer i offers a token
//  src_DATA   in   NUM_SRC*DATA_W  token data, slice i = [i*DATA_W +: DATA_W]
//  src_COUNT  in   NUM_SRC*CNT_W   ignored; every accepted SEND is one token
//  src_RDY    out  NUM_SRC         holding register i is empty
//  src_ACK    out  NUM_SRC         one-cycle pulse: token i was captured
//  dst_SEND   out  1               output token valid
//  dst_DATA   out  DATA_W          output token data
//  dst_COUNT  out  CNT_W           1 while dst_SEND, else 0
//  dst_SRC    out  SRC_W           index of the source that produced the token
//  dst_RDY    in   1               consumer can accept
// BEHAVIOUR
//  - Reset (RESET high, async): all hv[i]=0 and ov=0; ptr=0; src_ACK=0.
//    Outputs: dst_SEND=0, dst_DATA=0, dst_COUNT=0, dst_SRC=0, src_RDY=all 1.
//    In-flight tokens are dropped; no ACK is issued for them.
//  - src_RDY[i] = ~hv[i]. This is a flop output with no combinational path from dst_RDY.
//  - Capture: on an edge with src_SEND[i]&src_RDY[i], set hv[i]=1 and hd[i]=src_DATA slice.
//    src_ACK[i] is high for exactly the next cycle.
//  - SEND while RDY is low is ignored. The producer must hold or retry.
//  - Output transfer occurs on a cycle with dst_SEND&dst_RDY.
//  - Output stage free = ~ov | dst_RDY.
//  - Grant: on an edge where the output stage is free and any hv is set:
//    g = first i with hv[i] set, scanning ptr, ptr+1, ... (mod NUM_SRC).
//    Load ov=1, od=hd[g], osrc=g; clear hv[g]; set ptr=(g+1) mod NUM_SRC.
//  - Free and no hv set: ov clears. dst_DATA and dst_SRC hold their last values.
//  - Not free (dst_SEND=1, dst_RDY=0): od, osrc and ov are held stable. No grant.
//  - Capture into hv[i] and grant from hv[j] on the same edge are independent.
//    Capture and grant cannot hit the same i because src_RDY[i]=0 while hv[i]=1.
//  - Latency: src_SEND sampled at edge k gives dst_SEND at cycle k+2 at earliest.
//  - Throughput: 1 token/cycle aggregate; 1 token per 2 cycles per source.
//  - Ordering: tokens from one source leave in arrival order.
//  - State per source: EMPTY (hv=0) -> FULL on capture -> EMPTY on grant.
//  - Output stage: IDLE (ov=0) -> BUSY on grant.
//    BUSY stays BUSY on transfer with a new grant; BUSY -> IDLE on transfer with no grant.
// CONFIGURATION
//  TOKEN_ARB_FIXED_PRIO_EN
//   defined: fixed priority, lowest pending index always wins. ptr is removed.
//   undefined (default): round-robin as above.
//   Ports and latency are identical in both modes.
// TESTING
//  1 Reset: RESET=1 mid-stream with ov=1, hv=2'b11.
//    -> same cycle dst_SEND=0, src_RDY=2'b11; no src_ACK after release.
//  2 Single token: src_SEND[0] with 8'h15 at cycle 0, dst_RDY=1.
//    -> src_ACK[0]=1 at cycle 1; dst_SEND=1 at cycle 2 only, DATA 8'h15, SRC 0, COUNT 1.
//  3 Round-robin: src0 sends 8'h15 at c0 (granted, ptr=1).
//    Then both send at c2: src0 8'h06, src1 8'h18.
//    -> output order 8'h15(0), 8'h18(1), 8'h06(0).
//  4 Backpressure: dst_RDY=0 for 5 cycles with both sources sending.
//    -> dst_SEND held, DATA/SRC stable; src_RDY=2'b00 after fill.
//    Raise dst_RDY -> 2 tokens drain on consecutive cycles, no loss or duplication.
//  5 Streaming: both sources offer back-to-back tokens, dst_RDY=1 for 20 cycles.
//    -> 1 token/cycle, dst_SRC alternates 0,1,0,1; per-source data order preserved.
//  6 TOKEN_ARB_FIXED_PRIO_EN defined, stimulus as in scenario 3.
//    -> output order 8'h15(0), 8'h06(0), 8'h18(1).

Source files
------------

// File: rtl/actor_token_arbiter.sv
// actor_token_arbiter
//  Merges the SEND/RDY/ACK token ports of NUM_SRC dataflow actors onto one
//  consumer port. Each source has a one-token holding register. Arbitration
//  moves one held token per cycle into a registered output stage.
//  Build option: TOKEN_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, the lowest pending index always wins.
//   undefined -> round-robin starting after the last granted source.
//  Ports and latency are the same in both modes.
`timescale 1ns/1ps
module actor_token_arbiter #(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16,
   parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                        CLK,
   input  logic                        RESET,
   input  logic [NUM_SRC-1:0]          src_SEND,
   input  logic [NUM_SRC*DATA_W-1:0]   src_DATA,
   input  logic [NUM_SRC*CNT_W-1:0]    src_COUNT,
   output logic [NUM_SRC-1:0]          src_RDY,
   output logic [NUM_SRC-1:0]          src_ACK,
   output logic                        dst_SEND,
   output logic [DATA_W-1:0]           dst_DATA,
   output logic [CNT_W-1:0]            dst_COUNT,
   output logic [SRC_W-1:0]            dst_SRC,
   input  logic                        dst_RDY
);

   // Holding registers, one token per source
   logic [NUM_SRC-1:0] hv_q, hv_d;
   logic [DATA_W-1:0]  hd_q [NUM_SRC];
   logic [DATA_W-1:0]  hd_d [NUM_SRC];
   logic [NUM_SRC-1:0] ack_q, ack_d;

   // Output stage
   logic               ov_q, ov_d;
   logic [DATA_W-1:0]  od_q, od_d;
   logic [SRC_W-1:0]   osrc_q, osrc_d;

`ifndef TOKEN_ARB_FIXED_PRIO_EN
   // Round-robin start position: one past the last granted source
   logic [SRC_W-1:0]   ptr_q, ptr_d;
`endif

   logic [NUM_SRC-1:0] cap_s;
   logic [NUM_SRC-1:0] gnt_oh_s;
   logic               gnt_vld_s;
   logic [SRC_W-1:0]   gnt_idx_s;
   logic               free_s;
   logic               grant_s;

   // Every accepted SEND is exactly one token, so COUNT carries no information
   logic               unused_cnt_s;
   assign unused_cnt_s = ^src_COUNT;

   // Select the pending holding register that wins the output stage
   always_comb begin : arb_pick
`ifndef TOKEN_ARB_FIXED_PRIO_EN
      logic [SRC_W:0]   sum_v;
      logic [SRC_W-1:0] idx_v;
`endif
      gnt_vld_s = 1'b0;
      gnt_idx_s = {SRC_W{1'b0}};
`ifdef TOKEN_ARB_FIXED_PRIO_EN
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!gnt_vld_s && hv_q[k]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = SRC_W'(k);
         end else begin
            gnt_vld_s = gnt_vld_s;
         end
      end
`else
      sum_v = {(SRC_W+1){1'b0}};
      idx_v = {SRC_W{1'b0}};
      for (int k = 0; k < NUM_SRC; k++) begin
         // Candidate index (ptr + k) mod NUM_SRC without a divider
         sum_v = {1'b0, ptr_q} + (SRC_W+1)'(k);
         idx_v = (sum_v >= (SRC_W+1)'(NUM_SRC)) ?
                 SRC_W'(sum_v - (SRC_W+1)'(NUM_SRC)) : sum_v[SRC_W-1:0];
         if (!gnt_vld_s && hv_q[idx_v]) begin
            gnt_vld_s = 1'b1;
            gnt_idx_s = idx_v;
         end else begin
            gnt_vld_s = gnt_vld_s;
         end
      end
`endif
   end

   // Next-state for capture, grant and the output stage
   always_comb begin : next_state
      free_s   = ~ov_q | dst_RDY;
      grant_s  = free_s & gnt_vld_s;
      // A source can only be captured while its register is empty, so a
      // capture and a grant never target the same index on one edge
      cap_s    = src_SEND & ~hv_q;
      gnt_oh_s = grant_s ? (NUM_SRC'(1) << gnt_idx_s) : {NUM_SRC{1'b0}};
      hv_d     = (hv_q & ~gnt_oh_s) | cap_s;
      ack_d    = cap_s;
      for (int i = 0; i < NUM_SRC; i++) begin
         hd_d[i] = cap_s[i] ? src_DATA[i*DATA_W +: DATA_W] : hd_q[i];
      end

      ov_d   = ov_q;
      od_d   = od_q;
      osrc_d = osrc_q;
      if (grant_s) begin
         ov_d   = 1'b1;
         od_d   = hd_q[gnt_idx_s];
         osrc_d = gnt_idx_s;
      end else if (free_s) begin
         // Drained with nothing pending: data and source id keep last values
         ov_d   = 1'b0;
      end else begin
         // Stalled by the consumer: hold the token stable
         ov_d   = ov_q;
      end

`ifndef TOKEN_ARB_FIXED_PRIO_EN
      if (grant_s) begin
         ptr_d = (gnt_idx_s == SRC_W'(NUM_SRC-1)) ? {SRC_W{1'b0}} : gnt_idx_s + SRC_W'(1);
      end else begin
         ptr_d = ptr_q;
      end
`endif
   end

   // State registers; reset drops any in-flight tokens without ACK
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hv_q   <= {NUM_SRC{1'b0}};
         ack_q  <= {NUM_SRC{1'b0}};
         ov_q   <= 1'b0;
         od_q   <= {DATA_W{1'b0}};
         osrc_q <= {SRC_W{1'b0}};
         for (int i = 0; i < NUM_SRC; i++) begin
            hd_q[i] <= {DATA_W{1'b0}};
         end
`ifndef TOKEN_ARB_FIXED_PRIO_EN
         ptr_q  <= {SRC_W{1'b0}};
`endif
      end else begin
         hv_q   <= hv_d;
         ack_q  <= ack_d;
         ov_q   <= ov_d;
         od_q   <= od_d;
         osrc_q <= osrc_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            hd_q[i] <= hd_d[i];
         end
`ifndef TOKEN_ARB_FIXED_PRIO_EN
         ptr_q  <= ptr_d;
`endif
      end
   end

   // All outputs come straight from flops; RDY has no path from dst_RDY
   assign src_RDY   = ~hv_q;
   assign src_ACK   = ack_q;
   assign dst_SEND  = ov_q;
   assign dst_DATA  = od_q;
   assign dst_SRC   = osrc_q;
   assign dst_COUNT = CNT_W'(ov_q);

endmodule

// File: tb/tb_actor_token_arbiter.sv
// tb_actor_token_arbiter
//  Directed bench for actor_token_arbiter with two sources. Expected token
//  order follows the build option TOKEN_ARB_FIXED_PRIO_EN.
`timescale 1ns/1ps
module tb_actor_token_arbiter;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [1:0]  src_SEND;
   logic [15:0] src_DATA;
   logic [31:0] src_COUNT;
   logic [1:0]  src_RDY;
   logic [1:0]  src_ACK;
   logic        dst_SEND;
   logic [7:0]  dst_DATA;
   logic [15:0] dst_COUNT;
   logic [0:0]  dst_SRC;
   logic        dst_RDY;

   actor_token_arbiter #(
      .NUM_SRC (2),
      .DATA_W  (8),
      .CNT_W   (16),
      .SRC_W   (1)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .src_SEND  (src_SEND),
      .src_DATA  (src_DATA),
      .src_COUNT (src_COUNT),
      .src_RDY   (src_RDY),
      .src_ACK   (src_ACK),
      .dst_SEND  (dst_SEND),
      .dst_DATA  (dst_DATA),
      .dst_COUNT (dst_COUNT),
      .dst_SRC   (dst_SRC),
      .dst_RDY   (dst_RDY)
   );

   // Free-running clock
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int mark;

   // Cycle counter used to timestamp output transfers
   always @(posedge CLK) cyc <= cyc + 1;

   // Log of accepted output tokens
   logic [7:0] mq_data[$];
   logic       mq_src[$];
   int         mq_cyc[$];

   // Record every token the consumer accepts on the coming edge
   always @(negedge CLK) begin
      if (!RESET && dst_SEND && dst_RDY) begin
         mq_data.push_back(dst_DATA);
         mq_src.push_back(dst_SRC[0]);
         mq_cyc.push_back(cyc);
      end
   end

   // Producer token lists and positions
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int         p0, p1;

   // Expected orders per arbitration mode
   logic [7:0] e3d[3];
   logic       e3s[3];
   logic [7:0] e4d[4];
   logic       e4s[4];
   logic [7:0] e4_next;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic apply_src();
      src_SEND[0]   = (p0 < q0.size());
      src_DATA[7:0] = (p0 < q0.size()) ? q0[p0] : 8'h00;
      src_SEND[1]   = (p1 < q1.size());
      src_DATA[15:8] = (p1 < q1.size()) ? q1[p1] : 8'h00;
   endtask

   // Advance one clock; producers move to their next token after ACK
   task automatic step();
      @(posedge CLK);
      #1;
      if (src_ACK[0]) p0++;
      if (src_ACK[1]) p1++;
      apply_src();
   endtask

   task automatic clear_src();
      q0.delete();
      q1.delete();
      p0 = 0;
      p1 = 0;
      apply_src();
   endtask

   task automatic do_reset();
      #2;
      RESET = 1'b1;
      clear_src();
      dst_RDY = 1'b0;
      step();
      step();
      RESET = 1'b0;
   endtask

   initial begin
`ifdef TOKEN_ARB_FIXED_PRIO_EN
      e3d = '{8'h15, 8'h06, 8'h18};
      e3s = '{1'b0, 1'b0, 1'b1};
      e4d = '{8'h40, 8'h41, 8'h50, 8'h51};
      e4s = '{1'b0, 1'b0, 1'b1, 1'b1};
      e4_next = 8'h41;
`else
      e3d = '{8'h15, 8'h18, 8'h06};
      e3s = '{1'b0, 1'b1, 1'b0};
      e4d = '{8'h40, 8'h50, 8'h41, 8'h51};
      e4s = '{1'b0, 1'b1, 1'b0, 1'b1};
      e4_next = 8'h50;
`endif
      src_COUNT = 32'h0007_0003;
      dst_RDY   = 1'b0;
      clear_src();

      // Reset values
      #1;
      check_val("rst_send",  32'(dst_SEND),  32'h0);
      check_val("rst_rdy",   32'(src_RDY),   32'h3);
      check_val("rst_ack",   32'(src_ACK),   32'h0);
      check_val("rst_count", 32'(dst_COUNT), 32'h0);
      check_val("rst_data",  32'(dst_DATA),  32'h0);
      check_val("rst_src",   32'(dst_SRC),   32'h0);
      step();
      step();
      RESET = 1'b0;

      // Single token latency
      dst_RDY = 1'b1;
      mark = mq_data.size();
      q0.push_back(8'h15);
      apply_src();
      step();
      check_val("s2_ack_c1",   32'(src_ACK),   32'h1);
      check_val("s2_send_c1",  32'(dst_SEND),  32'h0);
      step();
      check_val("s2_send_c2",  32'(dst_SEND),  32'h1);
      check_val("s2_data_c2",  32'(dst_DATA),  32'h15);
      check_val("s2_src_c2",   32'(dst_SRC),   32'h0);
      check_val("s2_count_c2", 32'(dst_COUNT), 32'h1);
      check_val("s2_ack_c2",   32'(src_ACK),   32'h0);
      step();
      check_val("s2_send_c3",  32'(dst_SEND),  32'h0);
      check_val("s2_count_c3", 32'(dst_COUNT), 32'h0);
      check_val("s2_hold_c3",  32'(dst_DATA),  32'h15);
      check_val("s2_ntok",     32'(mq_data.size() - mark), 32'd1);

      // Arbitration order
      do_reset();
      dst_RDY = 1'b1;
      mark = mq_data.size();
      q0.push_back(8'h15);
      apply_src();
      step();
      step();
      q0.push_back(8'h06);
      q1.push_back(8'h18);
      apply_src();
      repeat (6) step();
      check_val("s3_ntok", 32'(mq_data.size() - mark), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_val("s3_data", 32'(mq_data[mark+i]), 32'(e3d[i]));
         check_val("s3_src",  32'(mq_src[mark+i]),  32'(e3s[i]));
      end

      // Backpressure
      do_reset();
      dst_RDY = 1'b0;
      mark = mq_data.size();
      q0.push_back(8'h40);
      q0.push_back(8'h41);
      q1.push_back(8'h50);
      q1.push_back(8'h51);
      apply_src();
      repeat (3) step();
      check_val("s4_rdy_full", 32'(src_RDY),  32'h0);
      check_val("s4_send",     32'(dst_SEND), 32'h1);
      check_val("s4_data",     32'(dst_DATA), 32'h40);
      check_val("s4_src",      32'(dst_SRC),  32'h0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_val("s4_hold_send", 32'(dst_SEND), 32'h1);
         check_val("s4_hold_data", 32'(dst_DATA), 32'h40);
         check_val("s4_hold_src",  32'(dst_SRC),  32'h0);
      end
      check_val("s4_no_leak", 32'(mq_data.size() - mark), 32'd0);
      dst_RDY = 1'b1;
      step();
      check_val("s4_next_send", 32'(dst_SEND), 32'h1);
      check_val("s4_next_data", 32'(dst_DATA), 32'(e4_next));
      repeat (6) step();
      check_val("s4_ntok", 32'(mq_data.size() - mark), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_val("s4_data_ord", 32'(mq_data[mark+i]), 32'(e4d[i]));
         check_val("s4_src_ord",  32'(mq_src[mark+i]),  32'(e4s[i]));
      end
      check_val("s4_b2b", 32'(mq_cyc[mark+1] - mq_cyc[mark]), 32'd1);
      check_val("s4_idle", 32'(dst_SEND), 32'h0);

      // Reset in the middle of traffic
      do_reset();
      dst_RDY = 1'b0;
      q0.push_back(8'hA0);
      q0.push_back(8'hA1);
      q1.push_back(8'hB0);
      apply_src();
      repeat (3) step();
      check_val("s1_pre_rdy",  32'(src_RDY),  32'h0);
      check_val("s1_pre_send", 32'(dst_SEND), 32'h1);
      #2;
      RESET = 1'b1;
      #1;
      check_val("s1_send",  32'(dst_SEND),  32'h0);
      check_val("s1_rdy",   32'(src_RDY),   32'h3);
      check_val("s1_count", 32'(dst_COUNT), 32'h0);
      check_val("s1_data",  32'(dst_DATA),  32'h0);
      clear_src();
      step();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("s1_ack_after", 32'(src_ACK),  32'h0);
         check_val("s1_send_after", 32'(dst_SEND), 32'h0);
      end

      // Streaming from both sources
      do_reset();
      dst_RDY = 1'b1;
      mark = mq_data.size();
      for (int k = 0; k < 10; k++) begin
         q0.push_back(8'h10 + 8'(k));
         q1.push_back(8'h80 + 8'(k));
      end
      apply_src();
      repeat (26) step();
      check_val("s5_ntok", 32'(mq_data.size() - mark), 32'd20);
      if (mq_data.size() - mark >= 20) begin
         for (int i = 0; i < 20; i++) begin
            check_val("s5_src",  32'(mq_src[mark+i]), 32'(i % 2));
            check_val("s5_data", 32'(mq_data[mark+i]),
                      (i % 2 == 0) ? 32'(8'h10 + 8'(i/2)) : 32'(8'h80 + 8'(i/2)));
            if (i > 0) begin
               check_val("s5_rate", 32'(mq_cyc[mark+i] - mq_cyc[mark+i-1]), 32'd1);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
